// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULH = 2'b01,
        OP_UDIV  = 2'b10,
        OP_SDIV  = 2'b11
    } opE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } stateE;

    // Register index 31 reads as zero in the register file (XZR).
    localparam logic [4:0] XZR_IDX = 5'd31;

    // True for the two divide operations.
    function automatic logic isDivOp(input opE op);
        return (op == OP_UDIV) || (op == OP_SDIV);
    endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// Radix-2 shift/add multiplier and restoring divider sharing one
// accumulator pair (hi_r:lo_r). One step is performed per cycle while
// step is high; load initialises the registers from raw operands.
import mul_div_unit_pkg::*;

module mul_div_datapath #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] result
);

    opE               op_r;
    logic             negQuot_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             isSigned_s;
    logic [WIDTH-1:0] aMag_s;
    logic [WIDTH-1:0] bMag_s;
    logic [WIDTH:0]   mulSum_s;
    logic [WIDTH:0]   divShift_s;
    logic             divGeq_s;
    logic [WIDTH-1:0] divDiff_s;
    logic [WIDTH-1:0] hiNext_s;
    logic [WIDTH-1:0] loNext_s;

    // Operand magnitudes for signed divide; unsigned ops pass operands through.
    always_comb begin
        isSigned_s = (opE'(op) == OP_SDIV);
        if (isSigned_s && opA[WIDTH-1]) begin
            aMag_s = ~opA + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            aMag_s = opA;
        end
        if (isSigned_s && opB[WIDTH-1]) begin
            bMag_s = ~opB + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            bMag_s = opB;
        end
    end

    // One iteration: multiply adds the multiplicand when the low bit is set
    // then shifts right; divide shifts the remainder left and subtracts the
    // divisor when it fits (the true difference always fits in WIDTH bits).
    always_comb begin
        mulSum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        divShift_s = {hi_r, lo_r[WIDTH-1]};
        divGeq_s   = (divShift_s >= {1'b0, mcand_r});
        divDiff_s  = divShift_s[WIDTH-1:0] - mcand_r;
        if (isDivOp(op_r)) begin
            hiNext_s = divGeq_s ? divDiff_s : divShift_s[WIDTH-1:0];
            loNext_s = {lo_r[WIDTH-2:0], divGeq_s};
        end else begin
            hiNext_s = mulSum_s[WIDTH:1];
            loNext_s = {mulSum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Accumulator and operand registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_r      <= OP_MUL;
            negQuot_r <= 1'b0;
            mcand_r   <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else if (load) begin
            op_r      <= opE'(op);
            negQuot_r <= isSigned_s && (opA[WIDTH-1] ^ opB[WIDTH-1]);
            hi_r      <= {WIDTH{1'b0}};
            if (isDivOp(opE'(op))) begin
                mcand_r <= bMag_s;
                lo_r    <= aMag_s;
            end else begin
                mcand_r <= opA;
                lo_r    <= opB;
            end
        end else if (step) begin
            hi_r <= hiNext_s;
            lo_r <= loNext_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Select the product half or (sign-corrected) quotient.
    always_comb begin
        result = lo_r;
        case (op_r)
            OP_MUL:   result = lo_r;
            OP_UMULH: result = hi_r;
            OP_UDIV:  result = lo_r;
            OP_SDIV:  result = negQuot_r ? (~lo_r + {{(WIDTH-1){1'b0}}, 1'b1}) : lo_r;
            default:  result = lo_r;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage iterative multiply/divide unit: start/busy request side,
// valid/ack write-back side toward the register file BusW/RW path.
import mul_div_unit_pkg::*;

module mul_div_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [4:0]       Rd,
    output logic             Busy,
    output logic             WbValid,
    output logic [WIDTH-1:0] WbData,
    output logic [4:0]       WbRw,
    input  logic             WbAck
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    stateE            state_r;
    stateE            nextState_s;
    logic [CNT_W-1:0] counter_r;
    logic [4:0]       rd_r;
    logic             divZero_r;
    logic             accept_s;
    logic             divZero_s;
    logic             ackTaken_s;
    logic [WIDTH-1:0] dpResult_s;

    // Handshake decode: accept only in IDLE, ack only once the result is shown.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && Start;
        divZero_s  = isDivOp(opE'(Op)) && (OpB == {WIDTH{1'b0}});
        ackTaken_s = (state_r == ST_DONE) && WbValid && WbAck;
    end

    // Next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    nextState_s = divZero_s ? ST_DONE : ST_CALC;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (counter_r == LAST_CNT) begin
                    nextState_s = ST_DONE;
                end else begin
                    nextState_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (WbValid && WbAck) begin
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_DONE;
                end
            end
            default: nextState_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Iteration counter: cleared on accept, advances once per CALC cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            counter_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            counter_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_CALC) begin
            counter_r <= counter_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            counter_r <= counter_r;
        end
    end

    // Request-side latches: destination index and divide-by-zero flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_r      <= 5'd0;
            divZero_r <= 1'b0;
        end else if (accept_s) begin
            rd_r      <= Rd;
            divZero_r <= divZero_s;
        end else begin
            rd_r      <= rd_r;
            divZero_r <= divZero_r;
        end
    end

    mul_div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (accept_s),
        .step    (state_r == ST_CALC),
        .op      (Op),
        .opA     (OpA),
        .opB     (OpB),
        .result  (dpResult_s)
    );

    // Registered outputs: result captured once on the first DONE cycle and
    // held until the ack edge, so it is stable across the register file write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Busy    <= 1'b0;
            WbValid <= 1'b0;
            WbData  <= {WIDTH{1'b0}};
            WbRw    <= 5'd0;
        end else if (accept_s) begin
            Busy    <= 1'b1;
            WbValid <= 1'b0;
        end else if (ackTaken_s) begin
            Busy    <= 1'b0;
            WbValid <= 1'b0;
        end else if ((state_r == ST_DONE) && !WbValid) begin
            WbValid <= 1'b1;
            WbData  <= divZero_r ? {WIDTH{1'b0}} : dpResult_s;
            WbRw    <= rd_r;
        end else begin
            Busy    <= Busy;
            WbValid <= WbValid;
            WbData  <= WbData;
            WbRw    <= WbRw;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
import mul_div_unit_pkg::*;

module tb_mul_div_unit;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Op;
    logic [63:0] OpA;
    logic [63:0] OpB;
    logic [4:0]  Rd;
    logic        Busy;
    logic        WbValid;
    logic [63:0] WbData;
    logic [4:0]  WbRw;
    logic        WbAck;

    int checkCount = 0;
    int failCount  = 0;

    mul_div_unit #(.WIDTH(64), .CNT_W(6)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Op      (Op),
        .OpA     (OpA),
        .OpB     (OpB),
        .Rd      (Rd),
        .Busy    (Busy),
        .WbValid (WbValid),
        .WbData  (WbData),
        .WbRw    (WbRw),
        .WbAck   (WbAck)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one operation, measure latency, check result, then acknowledge.
    task automatic doOp(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] expData,
                        input int expLat, input int holdCycles, input bit glitchStart,
                        input bit ackWithStart);
        int cyc;
        int holdBad;
        Start = 1'b1;
        Op    = op;
        OpA   = a;
        OpB   = b;
        Rd    = rd;
        tick();
        Start = 1'b0;
        checkVal({tag, "_busy"}, 64'(Busy), 64'd1);
        cyc = 0;
        while (!WbValid && cyc < 200) begin
            if (glitchStart && cyc == 10) begin
                Start = 1'b1;
                Op    = OP_MUL;
                OpA   = 64'd9;
                OpB   = 64'd9;
                Rd    = 5'd1;
            end else begin
                Start = 1'b0;
            end
            tick();
            cyc++;
        end
        Start = 1'b0;
        checkVal({tag, "_lat"}, 64'(cyc), 64'(expLat));
        checkVal({tag, "_data"}, WbData, expData);
        checkVal({tag, "_rw"}, 64'(WbRw), 64'(rd));
        if (holdCycles > 0) begin
            holdBad = 0;
            for (int i = 0; i < holdCycles; i++) begin
                tick();
                if (WbValid !== 1'b1 || WbData !== expData || Busy !== 1'b1) holdBad++;
            end
            checkVal({tag, "_hold"}, 64'(holdBad), 64'd0);
        end
        WbAck = 1'b1;
        if (ackWithStart) begin
            Start = 1'b1;
            Op    = OP_MUL;
            OpA   = 64'd2;
            OpB   = 64'd3;
        end
        tick();
        WbAck = 1'b0;
        Start = 1'b0;
        checkVal({tag, "_ackvalid"}, 64'(WbValid), 64'd0);
        checkVal({tag, "_ackbusy"}, 64'(Busy), 64'd0);
        if (ackWithStart) begin
            tick();
            tick();
            checkVal({tag, "_noaccept"}, 64'(Busy), 64'd0);
        end
    endtask

    initial begin
        int badWb;
        Reset_n = 1'b0;
        Start   = 1'b0;
        Op      = 2'b00;
        OpA     = 64'd0;
        OpB     = 64'd0;
        Rd      = 5'd0;
        WbAck   = 1'b0;
        repeat (3) tick();
        checkVal("rst_busy", 64'(Busy), 64'd0);
        checkVal("rst_valid", 64'(WbValid), 64'd0);
        checkVal("rst_data", WbData, 64'd0);
        checkVal("rst_rw", 64'(WbRw), 64'd0);
        Reset_n = 1'b1;
        tick();

        doOp("mul",    OP_MUL,   64'h0000_0001_0000_0003, 64'h5, 5'd4,
             64'h0000_0005_0000_000F, 65, 10, 1'b0, 1'b0);
        doOp("umulh",  OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7,
             64'hFFFF_FFFF_FFFF_FFFE, 65, 0, 1'b0, 1'b0);
        doOp("mulones", OP_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
             64'h1, 65, 0, 1'b0, 1'b0);
        doOp("udiv",   OP_UDIV,  64'd100, 64'd7, 5'd9, 64'd14, 65, 0, 1'b0, 1'b0);
        doOp("sdivneg", OP_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd10,
             64'hFFFF_FFFF_FFFF_FFF2, 65, 0, 1'b0, 1'b0);
        doOp("sdivmin", OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
             64'h8000_0000_0000_0000, 65, 0, 1'b0, 1'b0);
        doOp("udivz",  OP_UDIV,  64'd123, 64'd0, 5'd12, 64'd0, 1, 0, 1'b0, 1'b0);
        doOp("sdivz",  OP_SDIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 5'd13, 64'd0, 1, 0, 1'b0, 1'b0);
        doOp("xzr",    OP_MUL,   64'd6, 64'd7, XZR_IDX, 64'd42, 65, 0, 1'b0, 1'b0);
        doOp("glitch", OP_UDIV,  64'd100, 64'd7, 5'd14, 64'd14, 65, 0, 1'b1, 1'b0);
        doOp("ackstart", OP_UMULH, 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 5'd15,
             64'h6, 65, 0, 1'b0, 1'b1);

        // Reset in the middle of a calculation aborts it without write-back.
        Start = 1'b1;
        Op    = OP_MUL;
        OpA   = 64'd11;
        OpB   = 64'd13;
        Rd    = 5'd3;
        tick();
        Start = 1'b0;
        repeat (20) tick();
        Reset_n = 1'b0;
        #2;
        checkVal("midrst_busy", 64'(Busy), 64'd0);
        checkVal("midrst_valid", 64'(WbValid), 64'd0);
        checkVal("midrst_data", WbData, 64'd0);
        tick();
        Reset_n = 1'b1;
        badWb = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (WbValid !== 1'b0 || Busy !== 1'b0) badWb++;
        end
        checkVal("midrst_nowb", 64'(badWb), 64'd0);
        doOp("postrst", OP_MUL, 64'd11, 64'd13, 5'd3, 64'd143, 65, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 64-bit multiply/divide unit in the execute stage.
- Consumes the register-file read buses (BusA/BusB values) with a start/busy handshake.
- Returns a 64-bit result plus destination register index as a write-back request that drives the register file's BusW/RW/RegWr path.
- Radix-2, one bit per cycle: small area, fixed latency.

Parameters:
- WIDTH, 64, operand/result width (only 64 is required to be supported)
- CNT_W, 6, iteration counter width (log2 WIDTH)

Ports:
- Clk  input  1  clock; all state updates on posedge
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  request pulse; sampled only in IDLE
- Op  input  2  00 MUL (low 64 of product), 01 UMULH (high 64, unsigned), 10 UDIV, 11 SDIV
- OpA  input  64  operand A (from BusA)
- OpB  input  64  operand B (from BusB)
- Rd  input  5  destination register index
- Busy  output  1  high from the cycle after accept until WbAck is taken
- WbValid  output  1  write-back request valid
- WbData  output  64  result (to BusW)
- WbRw  output  5  destination index (to RW)
- WbAck  input  1  write-back consumer accepted the result

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE; Busy, WbValid=0; WbData=0; WbRw=0; counter=0; internal operand/accumulator registers cleared.
  - Reset mid-operation aborts the operation; no write-back is issued.
- FSM states IDLE, CALC, DONE.
- IDLE:
  - Start=1 latches OpA, OpB, Rd, Op and goes to CALC, or to DONE for divide-by-zero.
  - Busy=1 from the next edge.
- CALC:
  - 64 iterations; counter counts 0..63. Leave to DONE on the edge where counter==63.
- DONE:
  - WbValid=1; WbData/WbRw stable and held until a cycle with WbAck=1.
  - On that edge: WbValid=0, Busy=0, go to IDLE.
  - WbAck in any other state is ignored.
- Latency:
  - Start sampled at edge N → WbValid high after edge N+65 for MUL/UMULH/UDIV/SDIV.
  - Divide-by-zero: WbValid high after edge N+1.
- Start while Busy=1 is ignored; no queueing.
- Start and WbAck in the same DONE cycle: only the ack takes effect; the new Start is not accepted until IDLE.
- Multiply:
  - Unsigned shift-add into a 128-bit accumulator.
  - MUL returns bits [63:0], UMULH returns bits [127:64].
  - MUL low half is sign-agnostic.
- UDIV:
  - Restoring division with a 65-bit partial remainder; quotient only returned.
- SDIV:
  - Divide the magnitudes, then negate the quotient if the operand signs differ; truncation toward zero.
  - 0x8000_0000_0000_0000 / -1 = 0x8000_0000_0000_0000 (wraps, no trap).
- Divide by zero (UDIV/SDIV, OpB==0): result 0 (ARMv8 semantics).
- Rd==31:
  - Write-back is still requested with WbRw=31 and WbData as computed.
  - The register file treats index 31 as XZR, so this keeps sequencing uniform.
- WbData is updated only on entry to DONE. The posedge-registered outputs are stable across the register file's negedge write.

Decomposition:
- Shared package holds:
  - op encodings OP_MUL=2'b00, OP_UMULH=2'b01, OP_UDIV=2'b10, OP_SDIV=2'b11
  - FSM state encodings ST_IDLE, ST_CALC, ST_DONE
  - XZR index constant 5'd31
- One natural sub-module, mul_div_datapath: accumulator, partial remainder, and shift/add/subtract step logic.
- mul_div_unit keeps the FSM, counter, handshake and output registers.

Test Plan:
- Reset: assert Reset_n=0 mid-CALC, release → Busy=0, WbValid=0, WbData=0; the next Start completes normally.
- MUL: OpA=0x0000_0001_0000_0003, OpB=0x5, Rd=4 → after edge N+65: WbValid=1, WbData=0x0000_0005_0000_000F, WbRw=4; held until WbAck.
- UMULH: OpA=OpB=0xFFFF_FFFF_FFFF_FFFF → WbData=0xFFFF_FFFF_FFFF_FFFE. Same operands with MUL → WbData=0x1.
- UDIV/SDIV:
  - UDIV 100/7 → 14.
  - SDIV -100/7 → 0xFFFF_FFFF_FFFF_FFF2 (-14).
  - SDIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000.
- Divide by zero: UDIV 123/0 → WbValid after edge N+1, WbData=0.
- Handshake:
  - Start pulsed while Busy → ignored; result matches the first operation only.
  - Hold WbAck=0 for 10 cycles in DONE → WbValid/WbData stable.
  - Start and WbAck together → back to IDLE, no new accept.
